udma_linch_sequencer: RTL and testbench
=======================================

Name: udma_linch_sequencer

Overview:
- Sequences one uDMA linear channel.
- Accepts a transfer configuration (start address, byte size, data size, continuous flag) from the channel's register file.
- Issues one L2 beat request per data unit to the core arbiter, advancing the current address and remaining byte count on each grant.
- Supports one queued (pending) configuration and continuous reload, and pulses an end-of-transfer event to the event unit.

Parameters:
- L2_AWIDTH_NOAL, 21, byte-address width of L2 (L2_ADDR_WIDTH+2).
- TRANS_SIZE, 20, width of size/bytes-left counters (max 1 MB transfer).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  transfer start byte address
- cfg_size_i  in  TRANS_SIZE  transfer size in bytes
- cfg_datasize_i  in  2  unit: 0=byte, 1=half, 2=word, 3=word
- cfg_continuous_i  in  1  reload on completion
- cfg_en_i  in  1  one-cycle pulse: start or queue configuration
- cfg_clr_i  in  1  one-cycle pulse: abort and flush
- cfg_en_o  out  1  channel running
- cfg_pending_o  out  1  queued configuration held
- cfg_curr_addr_o  out  L2_AWIDTH_NOAL  address of next beat
- cfg_bytes_left_o  out  TRANS_SIZE  bytes remaining in active transfer
- ch_ready_i  in  1  peripheral can accept/produce a beat
- ch_req_o  out  1  beat request to core arbiter
- ch_gnt_i  in  1  arbiter grant, same cycle as ch_req_o
- ch_addr_o  out  L2_AWIDTH_NOAL  beat address (= cfg_curr_addr_o)
- ch_datasize_o  out  2  beat data size of active transfer
- ch_event_o  out  1  one-cycle end-of-transfer pulse

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Active and shadow configurations cleared.
- Unit size: U = 1 for datasize 0, 2 for datasize 1, 4 for datasize 2 or 3.
- States:
  - IDLE: cfg_en_i with cfg_size_i != 0 loads the active config (curr_addr = startaddr, bytes_left = size); next cycle RUN.
  - IDLE: cfg_en_i with size 0 is ignored; no event.
  - RUN: ch_req_o = ch_ready_i (combinational); ch_datasize_o = active datasize.
- Beat accepted (ch_req_o && ch_gnt_i):
  - curr_addr += U, modulo 2^L2_AWIDTH_NOAL (wraps).
  - Non-last beat: bytes_left -= U.
  - Last beat when bytes_left <= U: bytes_left forced to 0, no underflow. A non-multiple size completes with a full final beat.
- Last-beat completion, in priority order (ch_event_o pulses next cycle in all cases):
  1. Pending set: load shadow into active, clear pending, stay RUN with no idle cycle.
  2. Continuous: reload curr_addr/bytes_left from stored startaddr/size, stay RUN.
  3. Otherwise: go to IDLE, cfg_en_o = 0.
- cfg_en_i in RUN (size != 0):
  - Captured into shadow; cfg_pending_o = 1 next cycle.
  - If pending is already set, shadow is overwritten.
- cfg_en_i in the same cycle as a last-beat grant:
  - The new config becomes active directly, as if pending.
  - Any existing pending config is discarded in favour of the newer one; pending = 0.
- cfg_clr_i:
  - Highest priority over grant and en in the same cycle.
  - Next cycle: IDLE, pending 0, bytes_left 0, curr_addr 0, no event.
  - A grant in the clear cycle is still delivered by the arbiter but not accounted.
- No request in IDLE; ch_req_o never asserts while cfg_en_o = 0.
- cfg_en_o = 1 exactly when state is RUN.
- Latency: cfg_en_i to first ch_req_o is 1 cycle. Grant to updated address is 1 cycle. Peak throughput is one beat per cycle.

Decomposition:
- udma_pkg gains ch_unit_t and a function datasize_to_unit(ch_datasize_t) returning U.
- Add typedef udma_linch_cfg_t: a packed struct of startaddr, size, datasize and continuous. It is used for both the active and shadow registers.
- Reuse existing ch_addr_t, ch_transize_t and ch_datasize_t.
- No sub-module: a single always_ff FSM plus counters.

Test Plan:
- Word transfer: addr 0x100, size 16, ds 2, ready/gnt always 1 → 4 beats at 0x100/104/108/10C; bytes_left 16→12→8→4→0; ch_event_o one pulse the cycle after the 4th grant; then IDLE.
- Odd size: ds 2, size 6 → 2 beats; bytes_left 6→2→0, no underflow; one event.
- Continuous: addr 0x40, size 4, ds 1, continuous → beats 0x40,0x42,0x40,0x42…; an event after every 2nd grant; cfg_en_o stays 1.
- Pending chain:
  - Start (0x0, 8, ds 0).
  - After 3 grants, en (0x200, 2, ds 0) → cfg_pending_o = 1.
  - After the 8th grant, the next beat is 0x200 with no gap.
  - 2 events total; pending cleared.
- Grant stall: ready 1, gnt toggling 1/0 → address advances only on gnt cycles; ch_req_o held.
- Clear mid-transfer: clr with gnt in the same cycle at bytes_left 8 → next cycle IDLE, bytes_left 0, pending 0, no event. Size-0 en → remains IDLE with no event.

Source files
------------

// File: rtl/udma_linch_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : udma_linch_sequencer_pkg                                           |
// | Brief   : Shared types and helpers for the uDMA linear channel sequencer.   |
// | Revision: 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package udma_linch_sequencer_pkg;

    localparam int unsigned CH_AWIDTH = 21;
    localparam int unsigned CH_TWIDTH = 20;

    typedef logic [CH_AWIDTH-1:0] ch_addr_t;
    typedef logic [CH_TWIDTH-1:0] ch_transize_t;
    typedef logic [1:0]           ch_datasize_t;
    typedef logic [2:0]           ch_unit_t;

    typedef struct packed {
        ch_addr_t     startaddr;
        ch_transize_t size;
        ch_datasize_t datasize;
        logic         continuous;
    } udma_linch_cfg_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } linch_state_e;

    // Bytes moved per beat; datasize 3 is treated as a word.
    function automatic ch_unit_t datasize_to_unit(input ch_datasize_t ds);
        case (ds)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/udma_linch_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | Module  : udma_linch_sequencer_if                                            |
// | Brief   : Beat request / grant bus between the channel and core arbiter.    |
// | Revision: 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface udma_linch_sequencer_if;
    import udma_linch_sequencer_pkg::*;

    logic         ch_ready;
    logic         ch_req;
    logic         ch_gnt;
    ch_addr_t     ch_addr;
    ch_datasize_t ch_datasize;
    logic         ch_event;

    modport master (
        input  ch_ready,
        input  ch_gnt,
        output ch_req,
        output ch_addr,
        output ch_datasize,
        output ch_event
    );

    modport slave (
        output ch_ready,
        output ch_gnt,
        input  ch_req,
        input  ch_addr,
        input  ch_datasize,
        input  ch_event
    );

endinterface

`default_nettype wire

// File: rtl/udma_linch_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : udma_linch_sequencer                                               |
// | Brief   : Linear uDMA channel sequencer with one queued config and reload.  |
// | Revision: 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module udma_linch_sequencer
    import udma_linch_sequencer_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL = CH_AWIDTH,
    parameter int unsigned TRANS_SIZE     = CH_TWIDTH
) (
    input  wire logic                      clk_i,
    input  wire logic                      rst_i,
    input  wire logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  wire logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  wire logic [1:0]                cfg_datasize_i,
    input  wire logic                      cfg_continuous_i,
    input  wire logic                      cfg_en_i,
    input  wire logic                      cfg_clr_i,
    output logic                           cfg_en_o,
    output logic                           cfg_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0]      cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]          cfg_bytes_left_o,
    udma_linch_sequencer_if.master         ch
);

    linch_state_e    state_q,   state_d;
    udma_linch_cfg_t active_q,  active_d;
    udma_linch_cfg_t shadow_q,  shadow_d;
    logic            pending_q, pending_d;
    ch_addr_t        addr_q,    addr_d;
    ch_transize_t    left_q,    left_d;
    logic            event_q,   event_d;

    ch_unit_t        w_unit;
    ch_addr_t        w_unit_addr;
    ch_transize_t    w_unit_len;
    udma_linch_cfg_t w_new_cfg;
    logic            w_en_valid;
    logic            w_req;
    logic            w_beat;
    logic            w_last;

    assign w_unit      = datasize_to_unit(active_q.datasize);
    assign w_unit_addr = {{(CH_AWIDTH-3){1'b0}}, w_unit};
    assign w_unit_len  = {{(CH_TWIDTH-3){1'b0}}, w_unit};

    assign w_new_cfg   = '{startaddr:  cfg_startaddr_i,
                           size:       cfg_size_i,
                           datasize:   cfg_datasize_i,
                           continuous: cfg_continuous_i};
    assign w_en_valid  = cfg_en_i && (cfg_size_i != '0);

    assign w_req  = (state_q == ST_RUN) && ch.ch_ready;
    assign w_beat = w_req && ch.ch_gnt;
    // A short final beat still moves a full unit; the counter saturates at 0.
    assign w_last = w_beat && (left_q <= w_unit_len);

    assign cfg_en_o         = (state_q == ST_RUN);
    assign cfg_pending_o    = pending_q;
    assign cfg_curr_addr_o  = addr_q;
    assign cfg_bytes_left_o = left_q;
    assign ch.ch_req        = w_req;
    assign ch.ch_addr       = addr_q;
    assign ch.ch_datasize   = active_q.datasize;
    assign ch.ch_event      = event_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            addr_q    <= '0;
            left_q    <= '0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            event_q   <= event_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        left_d    = left_q;
        event_d   = 1'b0;

        if (cfg_clr_i) begin
            state_d   = ST_IDLE;
            active_d  = '0;
            shadow_d  = '0;
            pending_d = 1'b0;
            addr_d    = '0;
            left_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_en_valid) begin
                        active_d = w_new_cfg;
                        addr_d   = cfg_startaddr_i;
                        left_d   = cfg_size_i;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        addr_d = addr_q + w_unit_addr;
                        left_d = w_last ? '0 : (left_q - w_unit_len);
                    end
                    // On completion a config arriving this cycle beats the queued one.
                    if (w_last) begin
                        event_d = 1'b1;
                        if (w_en_valid) begin
                            active_d  = w_new_cfg;
                            addr_d    = cfg_startaddr_i;
                            left_d    = cfg_size_i;
                            pending_d = 1'b0;
                        end else if (pending_q) begin
                            active_d  = shadow_q;
                            addr_d    = shadow_q.startaddr;
                            left_d    = shadow_q.size;
                            pending_d = 1'b0;
                        end else if (active_q.continuous) begin
                            addr_d = active_q.startaddr;
                            left_d = active_q.size;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (w_en_valid) begin
                        shadow_d  = w_new_cfg;
                        pending_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_udma_linch_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_udma_linch_sequencer                                            |
// | Brief   : Directed and random bench for udma_linch_sequencer.                |
// | Revision: 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_udma_linch_sequencer;
    import udma_linch_sequencer_pkg::*;

    localparam int unsigned C_AMASK = 32'h001F_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] cfg_startaddr;
    logic [19:0] cfg_size;
    logic [1:0]  cfg_ds;
    logic        cfg_cont;
    logic        cfg_en;
    logic        cfg_clr;
    logic        cfg_en_o;
    logic        cfg_pending_o;
    logic [20:0] cfg_curr_addr_o;
    logic [19:0] cfg_bytes_left_o;

    udma_linch_sequencer_if u_if ();

    udma_linch_sequencer u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_startaddr_i  (cfg_startaddr),
        .cfg_size_i       (cfg_size),
        .cfg_datasize_i   (cfg_ds),
        .cfg_continuous_i (cfg_cont),
        .cfg_en_i         (cfg_en),
        .cfg_clr_i        (cfg_clr),
        .cfg_en_o         (cfg_en_o),
        .cfg_pending_o    (cfg_pending_o),
        .cfg_curr_addr_o  (cfg_curr_addr_o),
        .cfg_bytes_left_o (cfg_bytes_left_o),
        .ch               (u_if.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int evcount;

    // Reference model: a transfer is (start, size, unit) plus a count of beats done.
    bit          m_run, m_pend, m_evt, m_cont, p_cont;
    int unsigned m_start, m_size, m_ds, m_k;
    int unsigned p_start, p_size, p_ds;

    logic [67:0] w_dut;
    assign w_dut = {cfg_en_o, cfg_pending_o, u_if.ch_req, u_if.ch_event, u_if.ch_datasize,
                    u_if.ch_addr, cfg_curr_addr_o, cfg_bytes_left_o};

    function automatic int unsigned unit_of(input int unsigned ds);
        return (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
    endfunction

    function automatic logic [67:0] exp_vec();
        int unsigned done, addr, left;
        logic [20:0] a;
        logic [19:0] l;
        logic [1:0]  d;
        done = m_k * unit_of(m_ds);
        addr = (m_start + done) & C_AMASK;
        left = (done >= m_size) ? 0 : m_size - done;
        a = addr[20:0];
        l = left[19:0];
        d = m_ds[1:0];
        return {m_run, m_pend, m_run && u_if.ch_ready, m_evt, d, a, a, l};
    endfunction

    task automatic model_load(input int unsigned s, input int unsigned z,
                              input int unsigned d, input bit c);
        m_start = s; m_size = z; m_ds = d; m_cont = c; m_k = 0;
    endtask

    task automatic model_update();
        int unsigned u;
        bit en_ok, beat, last;
        u     = unit_of(m_ds);
        en_ok = cfg_en && (cfg_size != 0);
        beat  = m_run && u_if.ch_ready && u_if.ch_gnt;
        m_evt = 1'b0;
        if (rst || cfg_clr) begin
            m_run = 0; m_pend = 0;
            model_load(0, 0, 0, 0);
        end else if (!m_run) begin
            if (en_ok) begin
                model_load(cfg_startaddr, cfg_size, cfg_ds, cfg_cont);
                m_run = 1;
            end
        end else begin
            last = beat && ((m_k + 1) * u >= m_size);
            if (beat) m_k++;
            if (last) begin
                m_evt = 1'b1;
                if (en_ok) begin
                    model_load(cfg_startaddr, cfg_size, cfg_ds, cfg_cont);
                    m_pend = 0;
                end else if (m_pend) begin
                    model_load(p_start, p_size, p_ds, p_cont);
                    m_pend = 0;
                end else if (m_cont) begin
                    m_k = 0;
                end else begin
                    m_run = 0;
                end
            end else if (en_ok) begin
                p_start = cfg_startaddr; p_size = cfg_size; p_ds = cfg_ds; p_cont = cfg_cont;
                m_pend = 1;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cfg_en  = 1'b0;
        cfg_clr = 1'b0;
    endtask

    task automatic set_cfg(input int unsigned a, input int unsigned s,
                           input int unsigned d, input bit c);
        cfg_startaddr = a[20:0];
        cfg_size      = s[19:0];
        cfg_ds        = d[1:0];
        cfg_cont      = c;
        cfg_en        = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.ch_ready = 1'b1; u_if.ch_gnt = 1'b1;
        set_cfg(32'h100, 16, 2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            cfg_en = 1'b1;
        end
        cfg_en = 1'b0;
        #1;
        checks++;
        if (w_dut !== 68'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", w_dut, 68'h0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (w_dut !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle: got %h want %h", w_dut, exp_vec());
        end
    endtask

    task automatic test_word_transfer();
        evcount = 0;
        set_cfg(32'h100, 16, 2, 0);
        for (int i = 0; i < 7; i++) begin
            u_if.ch_ready = 1'b1; u_if.ch_gnt = 1'b1; #1;
            checks++;
            if (w_dut !== exp_vec()) begin
                failures++;
                $display("FAIL word cycle %0d: got %h want %h", i, w_dut, exp_vec());
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (cfg_curr_addr_o !== 21'(32'h100 + 4 * (i - 1)) ||
                    cfg_bytes_left_o !== 20'(16 - 4 * (i - 1))) begin
                    failures++;
                    $display("FAIL word_beat %0d: addr %h left %0d", i, cfg_curr_addr_o, cfg_bytes_left_o);
                end
            end
            evcount += int'(u_if.ch_event);
            tick();
        end
        checks++;
        if (evcount != 1 || cfg_en_o !== 1'b0) begin
            failures++;
            $display("FAIL word_end: events %0d en %b want 1 0", evcount, cfg_en_o);
        end
    endtask

    task automatic test_odd_size();
        evcount = 0;
        set_cfg(32'h20, 6, 2, 0);
        for (int i = 0; i < 5; i++) begin
            u_if.ch_ready = 1'b1; u_if.ch_gnt = 1'b1; #1;
            checks++;
            if (w_dut !== exp_vec()) begin
                failures++;
                $display("FAIL odd cycle %0d: got %h want %h", i, w_dut, exp_vec());
            end
            evcount += int'(u_if.ch_event);
            tick();
        end
        checks++;
        if (evcount != 1 || cfg_bytes_left_o !== 20'd0) begin
            failures++;
            $display("FAIL odd_end: events %0d left %0d want 1 0", evcount, cfg_bytes_left_o);
        end
    endtask

    task automatic test_continuous();
        evcount = 0;
        set_cfg(32'h40, 4, 1, 1);
        for (int i = 0; i < 9; i++) begin
            u_if.ch_ready = 1'b1; u_if.ch_gnt = 1'b1; #1;
            checks++;
            if (w_dut !== exp_vec()) begin
                failures++;
                $display("FAIL cont cycle %0d: got %h want %h", i, w_dut, exp_vec());
            end
            evcount += int'(u_if.ch_event);
            tick();
        end
        checks++;
        if (evcount != 3 || cfg_en_o !== 1'b1) begin
            failures++;
            $display("FAIL cont_end: events %0d en %b want 3 1", evcount, cfg_en_o);
        end
        cfg_clr = 1'b1;
        tick();
    endtask

    task automatic test_pending_chain();
        evcount = 0;
        set_cfg(32'h0, 8, 0, 0);
        for (int i = 0; i < 13; i++) begin
            u_if.ch_ready = 1'b1; u_if.ch_gnt = 1'b1;
            if (i == 4) set_cfg(32'h200, 2, 0, 0);
            #1;
            checks++;
            if (w_dut !== exp_vec()) begin
                failures++;
                $display("FAIL pend cycle %0d: got %h want %h", i, w_dut, exp_vec());
            end
            if (i == 5 || i == 9) begin
                checks++;
                if ((i == 5 && cfg_pending_o !== 1'b1) || (i == 9 && cfg_curr_addr_o !== 21'h200)) begin
                    failures++;
                    $display("FAIL pend_point %0d: pending %b addr %h", i, cfg_pending_o, cfg_curr_addr_o);
                end
            end
            evcount += int'(u_if.ch_event);
            tick();
        end
        checks++;
        if (evcount != 2 || cfg_pending_o !== 1'b0 || cfg_en_o !== 1'b0) begin
            failures++;
            $display("FAIL pend_end: events %0d pending %b en %b want 2 0 0", evcount, cfg_pending_o, cfg_en_o);
        end
    endtask

    task automatic test_grant_stall();
        set_cfg(32'h80, 16, 2, 0);
        for (int i = 0; i < 12; i++) begin
            u_if.ch_ready = 1'b1; u_if.ch_gnt = i[0]; #1;
            checks++;
            if (w_dut !== exp_vec()) begin
                failures++;
                $display("FAIL stall cycle %0d: got %h want %h", i, w_dut, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_clear();
        evcount = 0;
        set_cfg(32'h1000, 32, 2, 0);
        for (int i = 0; i < 8; i++) begin
            u_if.ch_ready = 1'b1; u_if.ch_gnt = 1'b1;
            if (i == 3) set_cfg(32'h3000, 12, 1, 0);
            if (i == 7) cfg_clr = 1'b1;
            #1;
            if (i == 7) begin
                checks++;
                if (cfg_bytes_left_o !== 20'd8 || cfg_pending_o !== 1'b1) begin
                    failures++;
                    $display("FAIL clr_pre: left %0d pending %b want 8 1", cfg_bytes_left_o, cfg_pending_o);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (w_dut !== 68'h0 || w_dut !== exp_vec()) begin
            failures++;
            $display("FAIL clr_post: got %h want %h", w_dut, 68'h0);
        end
        set_cfg(32'h10, 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            evcount += int'(u_if.ch_event);
            tick();
        end
        checks++;
        if (cfg_en_o !== 1'b0 || evcount != 0 || u_if.ch_req !== 1'b0) begin
            failures++;
            $display("FAIL size0: en %b events %0d req %b want 0 0 0", cfg_en_o, evcount, u_if.ch_req);
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(32'h300, 8, 2, 0);
        for (int i = 0; i < 6; i++) begin
            u_if.ch_ready = 1'b1; u_if.ch_gnt = 1'b1;
            if (i == 1) set_cfg(32'h400, 4, 2, 0);
            if (i == 2) set_cfg(32'h500, 4, 2, 0);
            #1;
            checks++;
            if (w_dut !== exp_vec()) begin
                failures++;
                $display("FAIL b2b cycle %0d: got %h want %h", i, w_dut, exp_vec());
            end
            if (i == 3) begin
                checks++;
                if (cfg_curr_addr_o !== 21'h500 || cfg_pending_o !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_direct: addr %h pending %b want 500 0", cfg_curr_addr_o, cfg_pending_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int unsigned a;
        for (int i = 0; i < 800; i++) begin
            u_if.ch_ready = ($urandom_range(0, 3) != 0);
            u_if.ch_gnt   = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 3) == 0) ? (C_AMASK - $urandom_range(0, 7)) : ($urandom & C_AMASK);
                set_cfg(a, $urandom_range(0, 24), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            end
            cfg_clr = ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if (w_dut !== exp_vec()) begin
                failures++;
                $display("FAIL rand cycle %0d: got %h want %h", i, w_dut, exp_vec());
            end
            tick();
        end
        cfg_clr = 1'b1;
        tick();
    endtask

    initial begin
        cfg_startaddr = '0; cfg_size = '0; cfg_ds = '0; cfg_cont = 1'b0;
        cfg_en = 1'b0; cfg_clr = 1'b0; rst = 1'b1;
        u_if.ch_ready = 1'b0; u_if.ch_gnt = 1'b0;
        m_run = 0; m_pend = 0; m_evt = 0; m_cont = 0; p_cont = 0;
        m_start = 0; m_size = 0; m_ds = 0; m_k = 0; p_start = 0; p_size = 0; p_ds = 0;
        #2;
        test_reset();
        test_word_transfer();
        test_odd_size();
        test_continuous();
        test_pending_chain();
        test_grant_stall();
        test_clear();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
